// File: rtl/iob_cache_write_buffer_iob_pkg.sv
// Shared constants for the cache write buffer.
// An entry is packed as {addr, wstrb, wdata}: data at the LSBs, then strobes,
// then the word address. The helpers give the field offsets for a data width.
package iob_cache_write_buffer_iob_pkg;

  localparam int DEPTH_W_DEF = 2;
  localparam int DATA_LSB    = 0;

  function automatic int strb_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_cache_write_buffer_iob_regarray.sv
// DEPTH x W register file: one synchronous write port and one asynchronous
// read port, so the FIFO head is visible the cycle after it is written.
// Ports: clk_i, we (write enable), widx/wdata (write port),
//        ridx (read index), rdata (combinational read data).
// Contents are deliberately not reset.
module iob_cache_write_buffer_iob_regarray #(
  parameter int DEPTH_W = 2,
  parameter int W       = 32
) (
  input  logic               clk_i,
  input  logic               we,
  input  logic [DEPTH_W-1:0] widx,
  input  logic [W-1:0]       wdata,
  input  logic [DEPTH_W-1:0] ridx,
  output logic [W-1:0]       rdata
);

  logic [W-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk_i)
    if (we) mem[widx] <= wdata;

  assign rdata = mem[ridx];

endmodule

// File: rtl/iob_cache_write_buffer_iob.sv
// Write-through FIFO between the cache front end and the back-end write
// channel. Front-end word writes are accepted in one cycle and presented in
// order, show-ahead, on a valid/ready channel.
// Ports: clk_i, reset_i (sync, active high);
//        push_i/addr_i/wstrb_i/wdata_i  - front-end write;
//        full_o/empty_o/level_o         - occupancy (registered-state only);
//        overflow_o                     - sticky dropped-push flag;
//        valid_o/addr_o/wstrb_o/wdata_o/ready_i - write channel head.
module iob_cache_write_buffer_iob
  import iob_cache_write_buffer_iob_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                push_i,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]  addr_i,
  input  logic [DATA_W/8-1:0]                 wstrb_i,
  input  logic [DATA_W-1:0]                   wdata_i,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [DEPTH_W:0]                    level_o,
  output logic                                overflow_o,
  output logic                                valid_o,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]  addr_o,
  output logic [DATA_W/8-1:0]                 wstrb_o,
  output logic [DATA_W-1:0]                   wdata_o,
  input  logic                                ready_i
);

  localparam int FE_NBYTES_W = $clog2(DATA_W / 8);
  localparam int AW          = ADDR_W - FE_NBYTES_W;
  localparam int SW          = DATA_W / 8;
  localparam int ENTRY_W     = AW + SW + DATA_W;
  localparam int STRB_LSB    = strb_lsb(DATA_W);
  localparam int ADDR_LSB    = addr_lsb(DATA_W);

  // Extra MSB on each pointer is the wrap bit that separates full from empty.
  logic [DEPTH_W:0]   wr_ptr, rd_ptr;
  logic               pop, push_ok;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]) &&
                   (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]);
  assign level_o = wr_ptr - rd_ptr;
  assign valid_o = ~empty_o;

  // A pop frees the head slot this cycle, so a push while full is accepted
  // only alongside a pop. No bypass: valid_o is 0 when empty, so no pop.
  assign pop     = valid_o & ready_i;
  assign push_ok = push_i & (~full_o | pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_i & full_o & ~pop) overflow_o <= 1'b1;
    end
  end

  assign wr_entry = {addr_i, wstrb_i, wdata_i};

  // A push never writes the head slot while it is valid (it only lands on
  // the head slot when full with a pop, i.e. the head is leaving), so the
  // head outputs stay stable during a stalled transfer.
  iob_cache_write_buffer_iob_regarray #(
    .DEPTH_W (DEPTH_W),
    .W       (ENTRY_W)
  ) u_regarray (
    .clk_i (clk_i),
    .we    (push_ok),
    .widx  (wr_ptr[DEPTH_W-1:0]),
    .wdata (wr_entry),
    .ridx  (rd_ptr[DEPTH_W-1:0]),
    .rdata (rd_entry)
  );

  assign wdata_o = rd_entry[DATA_LSB +: DATA_W];
  assign wstrb_o = rd_entry[STRB_LSB +: SW];
  assign addr_o  = rd_entry[ADDR_LSB +: AW];

endmodule

// File: tb/tb_iob_cache_write_buffer_iob.sv
module tb_iob_cache_write_buffer_iob;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0, push_i = 1'b0, ready_i = 1'b0;
  logic [29:0] addr_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic [31:0] wdata_i = '0;
  logic        full_o, empty_o, overflow_o, valid_o;
  logic [2:0]  level_o;
  logic [29:0] addr_o;
  logic [3:0]  wstrb_o;
  logic [31:0] wdata_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iob_cache_write_buffer_iob #(.ADDR_W(32), .DATA_W(32), .DEPTH_W(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .push_i(push_i), .addr_i(addr_i),
    .wstrb_i(wstrb_i), .wdata_i(wdata_i), .full_o(full_o), .empty_o(empty_o),
    .level_o(level_o), .overflow_o(overflow_o), .valid_o(valid_o),
    .addr_o(addr_o), .wstrb_o(wstrb_o), .wdata_o(wdata_o), .ready_i(ready_i)
  );

  task automatic chk(input string n, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  // Entry k as {addr, strb, data}; k=0 is the 0x040/0xF/0xDEADBEEF write.
  function automatic logic [65:0] ent(input int k);
    logic [3:0] s;
    if (k == 0) return {30'h10, 4'hF, 32'hDEADBEEF};
    case (k)
      1: s = 4'h1; 2: s = 4'h3; 3: s = 4'h7; 4: s = 4'hF; default: s = 4'h8;
    endcase
    return {30'h100 + 30'(k), s, 32'hA000_0000 + 32'(k)};
  endfunction

  typedef struct {
    logic rst, push, rdy;
    int   k;
    logic ev;
    int   el;
    logic ef, eo;
    int   hk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, push, input int k, input logic rdy,
                             input logic ev, input int el, input logic ef, eo,
                             input int hk);
    vec_t r;
    r.rst = rst; r.push = push; r.k = k; r.rdy = rdy;
    r.ev = ev; r.el = el; r.ef = ef; r.eo = eo; r.hk = hk;
    return r;
  endfunction

  // Scoreboard model for the sequence-driven part.
  logic [65:0] q[$];
  logic        m_ovf;

  task automatic run_cycle(input logic p, input logic r, input logic [65:0] e);
    logic m_pop, m_full;
    push_i = p; ready_i = r; reset_i = 1'b0;
    {addr_i, wstrb_i, wdata_i} = e;
    #1;
    if (q.size() > 0) chk("head", {addr_o, wstrb_o, wdata_o}, q[0]);
    m_pop  = (q.size() > 0) && r;
    m_full = (q.size() == 4);
    if (p && m_full && !m_pop) m_ovf = 1'b1;
    if (m_pop) void'(q.pop_front());
    if (p && (!m_full || m_pop)) q.push_back(e);
    @(posedge clk); #1;
    chk("sb_level", 66'(level_o), 66'(q.size()));
    chk("sb_valid", 66'(valid_o), 66'(q.size() > 0));
    chk("sb_full",  66'(full_o),  66'(q.size() == 4));
    chk("sb_ovf",   66'(overflow_o), 66'(m_ovf));
  endtask

  task automatic do_reset();
    reset_i = 1'b1; push_i = 1'b0; ready_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b0;
    q.delete(); m_ovf = 1'b0;
  endtask

  initial begin
    // rst push k rdy | valid level full ovf head
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,0,0, 1,1,0,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,0,0, 1,1,0,0,0));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0));
    // fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) tbl.push_back(v(0,1,i,0, 1,i,(i==4),0,1));
    tbl.push_back(v(0,1,5,0, 1,4,1,1,1));
    for (int i = 3; i >= 0; i--) tbl.push_back(v(0,0,0,1, (i>0),i,0,1,4-i+1));
    // full with simultaneous pop: accepted, new entry drained last
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    for (int i = 1; i <= 4; i++) tbl.push_back(v(0,1,i,0, 1,i,(i==4),0,1));
    tbl.push_back(v(0,1,5,1, 1,4,1,0,2));
    tbl.push_back(v(0,0,0,1, 1,3,0,0,3));
    tbl.push_back(v(0,0,0,1, 1,2,0,0,4));
    tbl.push_back(v(0,0,0,1, 1,1,0,0,5));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0));
    // reset with 3 stored entries, then recovery
    for (int i = 1; i <= 3; i++) tbl.push_back(v(0,1,i,0, 1,i,0,0,1));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,4,0, 1,1,0,0,4));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0));
    // ready while empty ignored; push into empty with ready: no bypass
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0));
    tbl.push_back(v(0,1,1,1, 1,1,0,0,1));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0));

    foreach (tbl[i]) begin
      reset_i = tbl[i].rst; push_i = tbl[i].push; ready_i = tbl[i].rdy;
      {addr_i, wstrb_i, wdata_i} = ent(tbl[i].k);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 66'(valid_o), 66'(tbl[i].ev));
      chk($sformatf("v%0d_level", i), 66'(level_o), 66'(tbl[i].el));
      chk($sformatf("v%0d_full", i),  66'(full_o),  66'(tbl[i].ef));
      chk($sformatf("v%0d_empty", i), 66'(empty_o), 66'(tbl[i].el == 0));
      chk($sformatf("v%0d_ovf", i),   66'(overflow_o), 66'(tbl[i].eo));
      if (tbl[i].ev) chk($sformatf("v%0d_head", i), {addr_o, wstrb_o, wdata_o}, ent(tbl[i].hk));
    end

    // continuous push+pop: pointers wrap, level never exceeds 1
    do_reset();
    for (int c = 0; c < 20; c++) begin
      run_cycle(1'b1, 1'b1, {30'(c * 3), 4'(c), 32'(c)});
      chk("cont_lvl_le1", 66'(level_o <= 3'd1), 66'd1);
    end
    run_cycle(1'b0, 1'b1, '0);

    // random traffic against the scoreboard
    do_reset();
    for (int c = 0; c < 10000; c++)
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                {30'($urandom), 4'($urandom), 32'($urandom)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
